// File: rtl/fir_mac_sequencer_if.sv
// Stream, coefficient and status bundle for the folded FIR sequencer.
// master drives samples/coefficients; slave is the sequencer itself.
interface fir_mac_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 32,
  parameter int IDX_W  = $clog2(NTAPS)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              coef_we;
  logic [IDX_W-1:0]  coef_addr;
  logic [DATA_W-1:0] coef_wdata;
  logic              coef_err;
  logic              hist_clr;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    output coef_we, coef_addr, coef_wdata, hist_clr,
    input  in_ready, out_valid, out_data, coef_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    input  coef_we, coef_addr, coef_wdata, hist_clr,
    output in_ready, out_valid, out_data, coef_err, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Folded FIR: one 16x16 MAC swept over NTAPS taps per sample.
// Owns sample ring, coefficient bank and tap-sequencing FSM.
module fir_mac_sequencer #(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 32,
  parameter int IDX_W  = $clog2(NTAPS)
) (
  input logic                clk,
  input logic                reset,
  fir_mac_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hist_q [NTAPS];
  logic [DATA_W-1:0] coef_q [NTAPS];
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  cur_q;
  logic [IDX_W-1:0]  tap_q;
  logic              coef_err_q;

  logic              accept;
  logic              clr;
  logic              cwr;
  logic              mac;
  logic              last;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] prod;

  assign rd_idx = cur_q - tap_q;
  assign prod   = coef_q[tap_q] * hist_q[rd_idx];
  assign last   = (tap_q == IDX_W'(NTAPS - 1));

  assign bus.in_ready  = (state_q == IDLE) && !bus.hist_clr && !reset;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.coef_err  = coef_err_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    clr     = 1'b0;
    cwr     = 1'b0;
    mac     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cwr    = bus.coef_we;
        clr    = bus.hist_clr;
        accept = bus.in_valid && bus.in_ready;
        if (accept) state_d = MAC;
      end
      MAC: begin
        mac = 1'b1;
        if (last) state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) hist_q[k] <= '0;
      wr_ptr_q <= '0;
    end else if (clr) begin
      for (int k = 0; k < NTAPS; k++) hist_q[k] <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (accept) hist_q[wr_ptr_q] <= bus.in_data;
      if (mac && last) wr_ptr_q <= cur_q + 1'b1;
    end
  end

  // Bank resets to a ramp so the block powers up as the legacy filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= DATA_W'(k);
      coef_err_q <= 1'b0;
    end else begin
      if (cwr) coef_q[bus.coef_addr] <= bus.coef_wdata;
      coef_err_q <= bus.coef_we && (state_q != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      tap_q      <= '0;
      cur_q      <= '0;
      out_data_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
      tap_q <= '0;
      cur_q <= wr_ptr_q;
    end else if (mac) begin
      acc_q <= acc_q + prod;
      tap_q <= tap_q + 1'b1;
      if (last) out_data_q <= acc_q + prod;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a sample-level FIR model
// checked every cycle plus hand-computed literal results.
module tb_fir_mac_sequencer;
  localparam int DW = 16;
  localparam int N  = 32;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.DATA_W(DW), .NTAPS(N)) bus ();

  fir_mac_sequencer #(.DATA_W(DW), .NTAPS(N), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // sample-level model
  logic [DW-1:0] m_coef [N];
  logic [DW-1:0] m_hist [N];
  int            m_ptr;
  int            m_mode;
  int            m_cnt;
  logic [DW-1:0] m_res;
  logic [DW-1:0] m_out;
  logic          m_err;
  logic          m_e;

  function automatic logic [DW-1:0] fir_now();
    longint s = 0;
    for (int k = 0; k < N; k++)
      s += longint'(m_coef[k]) * longint'(m_hist[(m_ptr - k + N) % N]);
    return DW'(s);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        m_coef[k] = DW'(k);
        m_hist[k] = '0;
      end
      m_ptr = 0; m_mode = 0; m_cnt = 0;
      m_out = '0; m_err = 1'b0; m_res = '0;
    end else begin
      m_e = bus.coef_we && (m_mode != 0);
      if (m_mode == 0) begin
        if (bus.coef_we) m_coef[bus.coef_addr] = bus.coef_wdata;
        if (bus.hist_clr) begin
          for (int k = 0; k < N; k++) m_hist[k] = '0;
          m_ptr = 0;
        end else if (bus.in_valid) begin
          m_hist[m_ptr] = bus.in_data;
          m_res = fir_now();
          m_ptr = (m_ptr + 1) % N;
          m_mode = 1;
          m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        m_cnt++;
        if (m_cnt == N) begin
          m_mode = 2;
          m_out = m_res;
        end
      end else if (bus.out_ready) begin
        m_mode = 0;
      end
      m_err = m_e;
    end
  end

  int cyc_n = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [DW-1:0] got[$];
  int lat_q[$];
  int err_cnt = 0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_mode == 2);
    chk("busy", bus.busy, m_mode != 0);
    chk("in_ready", bus.in_ready, m_mode == 0 && !bus.hist_clr && !reset);
    chk("coef_err", bus.coef_err, m_err);
    chk("out_data", bus.out_data, m_out);
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus.out_valid && !prev_v) lat_q.push_back(cyc_n - acc_cyc);
    prev_v = bus.out_valid;
    if (bus.coef_err) err_cnt++;
  end

  function automatic logic [31:0] gotv(input int i);
    if (i < 0 || i >= got.size()) return 32'hffff_ffff;
    return 32'(got[i]);
  endfunction

  function automatic logic [31:0] last_lat();
    if (lat_q.size() == 0) return 32'hffff_ffff;
    return 32'(lat_q[$]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (bus.busy && n < 500) begin
      cyc();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
    cyc();
  endtask

  task automatic send(input logic [DW-1:0] d);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    cyc();
    acc_cyc = cyc_n;
    bus.in_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input logic [DW-1:0] d);
    wait_ready();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = IW'(a);
    bus.coef_wdata = d;
    cyc();
    bus.coef_we = 1'b0;
  endtask

  task automatic impulse_run(input string tag);
    int base = got.size();
    send(16'd1);
    repeat (33) send(16'd0);
    drain();
    chk({tag, "_count"}, got.size() - base, 34);
    chk({tag, "_o0"}, gotv(base), 0);
    chk({tag, "_o1"}, gotv(base + 1), 1);
    chk({tag, "_o5"}, gotv(base + 5), 5);
    chk({tag, "_o31"}, gotv(base + 31), 31);
    chk({tag, "_o32"}, gotv(base + 32), 0);
    chk({tag, "_o33"}, gotv(base + 33), 0);
    chk({tag, "_lat"}, last_lat(), 32);
  endtask

  initial begin
    watchdog();
  end

  task automatic watchdog();
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  endtask

  initial begin
    int base;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.hist_clr   = 1'b0;
    #1 reset = 1'b1;
    repeat (3) cyc();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    reset = 1'b0;
    cyc();

    impulse_run("imp");

    base = got.size();
    repeat (40) send(16'd1);
    drain();
    chk("ones_n1", gotv(base), 0);
    chk("ones_n2", gotv(base + 1), 1);
    chk("ones_n10", gotv(base + 9), 45);
    chk("ones_n32", gotv(base + 31), 496);
    chk("ones_n40", gotv(base + 39), 496);

    wcoef(0, 16'd3);
    for (int k = 1; k < N; k++) wcoef(k, 16'd0);
    base = got.size();
    send(16'd7);
    drain();
    chk("c3x7", gotv(base), 21);
    wcoef(0, 16'h0100);
    send(16'h0100);
    drain();
    chk("trunc", gotv(base + 1), 0);

    err_cnt = 0;
    base = got.size();
    send(16'd5);
    repeat (5) cyc();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = 16'hffff;
    cyc();
    bus.coef_we = 1'b0;
    drain();
    chk("err_pulses", err_cnt, 1);
    chk("err_old_coef", gotv(base), 16'h0500);
    send(16'd2);
    drain();
    chk("err_unchanged", gotv(base + 1), 16'h0200);

    bus.out_ready = 1'b0;
    send(16'd1);
    repeat (42) cyc();
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_busy", bus.busy, 1);
    chk("hold_in_ready", bus.in_ready, 0);
    chk("hold_data", bus.out_data, 16'h0100);
    bus.out_ready = 1'b1;
    cyc();
    chk("post_hs_ready", bus.in_ready, 1);
    cyc();

    base = got.size();
    send(16'd9);
    repeat (15) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("midrst_busy", bus.busy, 0);
    repeat (40) cyc();
    chk("midrst_no_out", got.size() - base, 0);
    impulse_run("imp2");

    send(16'd5);
    send(16'd5);
    drain();
    bus.hist_clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd7;
    #1;
    chk("clr_in_ready", bus.in_ready, 0);
    cyc();
    bus.hist_clr = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    base = got.size();
    send(16'd1);
    drain();
    chk("clr_result", gotv(base), 0);
    chk("clr_count", got.size() - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Folded FIR controller: time-multiplexes one 16x16 multiply-accumulate over NTAPS taps instead of NTAPS parallel multipliers.
- Owns the sample history ring buffer, a programmable coefficient bank, and the tap-sequencing FSM.
- Uses valid/ready on both input and output sample streams.
- Arithmetic is bit-exact with the existing parallel FIR (unsigned, mod 2^16), so either filter can drive the same downstream.

Parameters:
- DATA_W, 16, sample/coefficient/accumulator width; all arithmetic is mod 2^DATA_W.
- NTAPS, 32, number of taps (power of two, >=2).
- IDX_W, $clog2(NTAPS), tap index / pointer width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  DATA_W  input sample
- out_valid  out  1  filtered result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  filtered result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  IDX_W  coefficient index k
- coef_wdata  in  DATA_W  coefficient value
- coef_err  out  1  one-cycle pulse when a coefficient write is rejected
- hist_clr  in  1  synchronous history clear request
- busy  out  1  high in MAC or OUT state

Behaviour:
- Reset (async, high):
  - State goes to IDLE; history[] = 0; wr_ptr = 0; acc = 0; tap = 0.
  - coef[k] = k for all k (matches the existing ramp filter).
  - Outputs during reset: out_valid=0, out_data=0, coef_err=0, busy=0, in_ready=0.
- Combinational outputs:
  - in_ready = (state==IDLE) && !hist_clr && !reset.
  - busy = (state!=IDLE).
- States IDLE, MAC, OUT.
- IDLE:
  - hist_clr=1: history[] and wr_ptr are zeroed at the edge. hist_clr has priority over in_valid.
  - Otherwise, in_valid && in_ready: in_data is written to history[wr_ptr], acc=0, tap=0, cur=wr_ptr, go to MAC.
- MAC, one tap per cycle:
  - acc <= acc + (coef[tap] * history[(cur - tap) mod NTAPS])[DATA_W-1:0].
  - The sum is also truncated to DATA_W.
  - Tap 0 uses the sample just accepted (bypass/forward it if the buffer is registered).
  - After tap NTAPS-1: wr_ptr <= cur+1 (wraps mod NTAPS), go to OUT.
- OUT:
  - out_valid=1 and out_data=acc, held stable until out_ready=1.
  - The handshake edge clears out_valid and returns to IDLE.
  - out_data keeps its last value after the handshake.
- Latency and throughput:
  - out_valid rises exactly NTAPS cycles after the accepting edge.
  - Best-case throughput is one sample per NTAPS+2 cycles.
- Coefficient writes:
  - Accepted only in IDLE; coef[coef_addr] is updated at the edge.
  - A coef_we in MAC/OUT is dropped, and coef_err pulses 1 cycle (registered, next cycle). The coefficient bank is unchanged.
  - A coefficient write and a sample accept in the same IDLE cycle: the write takes effect first, so the new coefficient is used for that sample.
- hist_clr in MAC/OUT is ignored.
- Reset mid-MAC/OUT: the pending result is discarded and all state returns to reset values.
- Ring wrap: wr_ptr wraps NTAPS-1 -> 0. Tap indexing wraps mod NTAPS.

Test Plan:
- Default coefficients, impulse then zeros: in_data=1 followed by 33 zeros -> outputs 0,1,2,...,31,0,0. Each out_valid occurs exactly 32 cycles after its accept.
- Default coefficients, constant input 1 for 40 samples -> output n (1-based) = n(n-1)/2 mod 2^16. Sample 32 gives 496; samples 33..40 hold 496.
- Write coef[0]=3 and coef[1..31]=0 in IDLE, then input 7 -> out_data=21. Repeat with coef[0]=0x0100 and input 0x0100 -> out_data=0x0000 (truncation).
- coef_we (addr 0, data 0xFFFF) during MAC -> coef_err high for exactly one cycle; result equals the old-coefficient value; coef[0] is unchanged on the next sample.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid/out_data stable, in_ready=0, busy=1. Raising out_ready -> handshake, and in_ready=1 on the next cycle.
- Assert reset for 1 cycle at MAC tap 15 -> out_valid never rises for that sample and coefficients return to k. A subsequent impulse reproduces the first scenario.
- hist_clr asserted in IDLE together with in_valid -> sample not taken (in_ready=0) and history is zeroed. Any nonzero history before the clear does not appear in later outputs.
